spart_buffered_core: RTL and testbench

SPART_BUFFERED_CORE -- requirements
Module: spart_buffered_core

---
 rtl/spart_pkg.sv | 38 +++
 rtl/spart_sync_fifo.sv | 94 +++++++++
 rtl/spart_buffered_core.sv | 221 ++++++++++++++++++++++
 tb/tb_spart_buffered_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared constants for the buffered SPART core. Holds the
//               register addresses, the status and control bit positions,
//               and the default baud divisor.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // Register map
    localparam logic [1:0] c_ADDR_DATA   = 2'b00;
    localparam logic [1:0] c_ADDR_STAT   = 2'b01;
    localparam logic [1:0] c_ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] c_ADDR_DIV_HI = 2'b11;

    // Status register bit positions (read of c_ADDR_STAT)
    localparam int c_STAT_RDA      = 0;
    localparam int c_STAT_TBR      = 1;
    localparam int c_STAT_TX_EMPTY = 2;
    localparam int c_STAT_RX_FULL  = 3;
    localparam int c_STAT_RX_OVR   = 4;
    localparam int c_STAT_TX_OVF   = 5;
    localparam int c_STAT_IE_RX    = 6;
    localparam int c_STAT_IE_TX    = 7;

    // Control register bit positions (write of c_ADDR_STAT)
    localparam int c_CTRL_CLR_ERR  = 0;
    localparam int c_CTRL_FLUSH_RX = 1;
    localparam int c_CTRL_FLUSH_TX = 2;
    localparam int c_CTRL_IE_RX    = 3;
    localparam int c_CTRL_IE_TX    = 4;

    // Baud divisor after reset
    localparam logic [15:0] c_DIV_RESET = 16'h0145;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spart_sync_fifo
// Description : Single-clock FIFO with first-word-fall-through head output.
//               Push on a full FIFO is accepted when a pop happens in the
//               same cycle; pop on an empty FIFO is ignored. Flush empties
//               the FIFO and overrides any same-cycle push or pop.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               flush         - discard all entries
//               push, i_data  - write request and data
//               pop           - advance the head
//               o_data        - current head entry (valid when !empty)
//               full, empty   - occupancy flags
//               count         - number of stored entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module spart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_CNT_W-1:0] w_count_d;

    assign full   = (r_count == c_FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign o_data = r_mem[r_rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH.
            if (w_push_ok) w_wr_ptr_d = r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  w_rd_ptr_d = r_rd_ptr + c_PTR_W'(1);
            w_count_d = r_count + {{c_PTR_W{1'b0}}, w_push_ok}
                                - {{c_PTR_W{1'b0}}, w_pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
        end
    end

    // Storage carries no reset; entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : spart_sync_fifo
`default_nettype wire

// File: rtl/spart_buffered_core.sv
`default_nettype none
// ============================================================================
// Module      : spart_buffered_core
// Description : Processor-side register block of a SPART with TX and RX
//               FIFOs, status/control register, baud divisor registers and
//               a registered interrupt request.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               iocs, iorw, ioaddr     - chip select, 1=read/0=write, address
//               databus                - bidirectional processor data bus
//               tx_data/valid/ready    - TX FIFO head towards the serializer
//               rx_data/valid          - received character, one-cycle pulse
//               baud_div, baud_load    - committed divisor and update pulse
//               rda, tbr, irq          - RX data avail, TX room, interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module spart_buffered_core
    import spart_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               DEPTH     = 16,
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(c_DIV_RESET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DIV_W-1:0]  baud_div,
    output logic              baud_load,
    output logic              rda,
    output logic              tbr,
    output logic              irq
);

    localparam int c_HI_W  = DIV_W - DATA_W;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Registered state
    logic              r_rx_ovr;
    logic              r_tx_ovf;
    logic              r_ie_rx;
    logic              r_ie_tx;
    logic [DATA_W-1:0] r_shadow;
    logic [DIV_W-1:0]  r_baud_div;
    logic              r_baud_load;
    logic              r_irq;

    // Next-state values
    logic              w_rx_ovr_d;
    logic              w_tx_ovf_d;
    logic              w_ie_rx_d;
    logic              w_ie_tx_d;
    logic [DATA_W-1:0] w_shadow_d;
    logic [DIV_W-1:0]  w_baud_div_d;
    logic              w_baud_load_d;
    logic              w_irq_d;

    // Bus decode
    logic              w_cs_rd;
    logic              w_cs_wr;
    logic              w_tx_push;
    logic              w_rx_pop;
    logic              w_ctrl_wr;
    logic              w_lo_wr;
    logic              w_hi_wr;
    logic              w_tx_pop;
    logic              w_rx_flush;
    logic              w_tx_flush;
    logic              w_clr_err;
    logic [DATA_W-1:0] w_rd_data;

    // FIFO status
    logic [DATA_W-1:0]  w_rx_head;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [c_CNT_W-1:0] w_rx_count;
    logic [c_CNT_W-1:0] w_tx_count;
    logic               w_unused;

    assign w_cs_rd    = iocs & iorw;
    assign w_cs_wr    = iocs & ~iorw;
    assign w_tx_push  = w_cs_wr & (ioaddr == c_ADDR_DATA);
    assign w_rx_pop   = w_cs_rd & (ioaddr == c_ADDR_DATA);
    assign w_ctrl_wr  = w_cs_wr & (ioaddr == c_ADDR_STAT);
    assign w_lo_wr    = w_cs_wr & (ioaddr == c_ADDR_DIV_LO);
    assign w_hi_wr    = w_cs_wr & (ioaddr == c_ADDR_DIV_HI);
    assign w_rx_flush = w_ctrl_wr & databus[c_CTRL_FLUSH_RX];
    assign w_tx_flush = w_ctrl_wr & databus[c_CTRL_FLUSH_TX];
    assign w_clr_err  = w_ctrl_wr & databus[c_CTRL_CLR_ERR];

    // tx_valid is held low during reset so the serializer never consumes an
    // entry that reset is about to discard.
    assign tx_valid  = ~w_tx_empty & ~rst;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign rda       = ~w_rx_empty;
    assign tbr       = ~w_tx_full;
    assign baud_div  = r_baud_div;
    assign baud_load = r_baud_load;
    assign irq       = r_irq;

    assign databus = w_cs_rd ? w_rd_data : {DATA_W{1'bz}};

    spart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (w_rx_flush),
        .push   (rx_valid),
        .i_data (rx_data),
        .pop    (w_rx_pop),
        .o_data (w_rx_head),
        .full   (w_rx_full),
        .empty  (w_rx_empty),
        .count  (w_rx_count)
    );

    spart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (w_tx_flush),
        .push   (w_tx_push),
        .i_data (databus),
        .pop    (w_tx_pop),
        .o_data (tx_data),
        .full   (w_tx_full),
        .empty  (w_tx_empty),
        .count  (w_tx_count)
    );

    // Read mux. Divisor reads return the committed value, not the shadow.
    always_comb begin
        w_rd_data = '0;
        case (ioaddr)
            c_ADDR_DATA: begin
                if (!w_rx_empty) w_rd_data = w_rx_head;
            end
            c_ADDR_STAT: begin
                w_rd_data[c_STAT_RDA]      = ~w_rx_empty;
                w_rd_data[c_STAT_TBR]      = ~w_tx_full;
                w_rd_data[c_STAT_TX_EMPTY] = w_tx_empty;
                w_rd_data[c_STAT_RX_FULL]  = w_rx_full;
                w_rd_data[c_STAT_RX_OVR]   = r_rx_ovr;
                w_rd_data[c_STAT_TX_OVF]   = r_tx_ovf;
                w_rd_data[c_STAT_IE_RX]    = r_ie_rx;
                w_rd_data[c_STAT_IE_TX]    = r_ie_tx;
            end
            c_ADDR_DIV_LO: w_rd_data = r_baud_div[DATA_W-1:0];
            c_ADDR_DIV_HI: w_rd_data[c_HI_W-1:0] = r_baud_div[DIV_W-1:DATA_W];
            default:       w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_rx_ovr_d    = r_rx_ovr;
        w_tx_ovf_d    = r_tx_ovf;
        w_ie_rx_d     = r_ie_rx;
        w_ie_tx_d     = r_ie_tx;
        w_shadow_d    = r_shadow;
        w_baud_div_d  = r_baud_div;
        w_baud_load_d = w_hi_wr;

        if (w_clr_err) begin
            w_rx_ovr_d = 1'b0;
            w_tx_ovf_d = 1'b0;
        end
        // A new drop in the same cycle as a clear wins, so no event is lost.
        // A full RX FIFO being read this cycle has room for the new byte.
        if (rx_valid && w_rx_full && !w_rx_pop) w_rx_ovr_d = 1'b1;
        if (w_tx_push && w_tx_full && !w_tx_pop) w_tx_ovf_d = 1'b1;

        if (w_ctrl_wr) begin
            w_ie_rx_d = databus[c_CTRL_IE_RX];
            w_ie_tx_d = databus[c_CTRL_IE_TX];
        end
        if (w_lo_wr) w_shadow_d = databus;
        if (w_hi_wr) w_baud_div_d = {databus[c_HI_W-1:0], r_shadow};

        w_irq_d = (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty) | r_rx_ovr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovr    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_ie_rx     <= 1'b0;
            r_ie_tx     <= 1'b0;
            r_shadow    <= DIV_RESET[DATA_W-1:0];
            r_baud_div  <= DIV_RESET;
            r_baud_load <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_rx_ovr    <= w_rx_ovr_d;
            r_tx_ovf    <= w_tx_ovf_d;
            r_ie_rx     <= w_ie_rx_d;
            r_ie_tx     <= w_ie_tx_d;
            r_shadow    <= w_shadow_d;
            r_baud_div  <= w_baud_div_d;
            r_baud_load <= w_baud_load_d;
            r_irq       <= w_irq_d;
        end
    end

    // Occupancy counts and the upper control bits have no consumer here.
    assign w_unused = ^{databus, w_rx_count, w_tx_count};

endmodule : spart_buffered_core
`default_nettype wire

// File: tb/tb_spart_buffered_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_buffered_core
// Description : Self-checking bench for spart_buffered_core. Register-level
//               vectors come from a table; TX and RX data are tracked by
//               expectation queues and compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_buffered_core;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 16;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              iocs     = 1'b0;
    logic              iorw     = 1'b0;
    logic [1:0]        ioaddr   = 2'b00;
    wire  [DATA_W-1:0] databus;
    logic [DATA_W-1:0] r_drv    = '0;
    logic              r_oe     = 1'b0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] rx_data  = '0;
    logic              rx_valid = 1'b0;
    logic [DIV_W-1:0]  baud_div;
    logic              baud_load;
    logic              rda;
    logic              tbr;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] tx_q[$];
    logic [DATA_W-1:0] rx_q[$];

    typedef struct {
        logic [1:0]        a0;
        logic [DATA_W-1:0] d0;
        logic [1:0]        a1;
        logic [DATA_W-1:0] d1;
        logic [1:0]        ra;
        logic [DATA_W-1:0] exp;
    } vec_t;

    assign databus = r_oe ? r_drv : {DATA_W{1'bz}};

    always #5 clk = ~clk;

    spart_buffered_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DIV_W     (DIV_W),
        .DIV_RESET (16'h0145)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .baud_div  (baud_div),
        .baud_load (baud_load),
        .rda       (rda),
        .tbr       (tbr),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
        if (a == 2'b00 && tx_q.size() < DEPTH) tx_q.push_back(d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; r_drv = d; r_oe = 1'b1;
        tick();
        iocs = 1'b0; r_oe = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [DATA_W-1:0] exp);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk);
        chk(name, {8'h00, databus}, {8'h00, exp});
        tick();
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic read_data(input string name);
        logic [DATA_W-1:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
        read_chk(name, 2'b00, exp);
    endtask

    task automatic rx_pulse(input logic [DATA_W-1:0] d);
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 60 && tx_q.size() != 0; i++) tick();
        chk(name, 16'(tx_q.size()), 16'd0);
        tx_ready = 1'b0;
        chk({name, "_valid"}, {15'd0, tx_valid}, 16'd0);
    endtask

    // TX scoreboard: each consumed head must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_pop: got=%h expected=<no entry> at %0t", tx_data, $time);
            end else begin
                chk("tx_data", {8'h00, tx_data}, {8'h00, tx_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{2'd2, 8'h45, 2'd3, 8'h01, 2'd2, 8'h45};
        vecs[1] = '{2'd2, 8'h34, 2'd3, 8'h12, 2'd3, 8'h12};
        vecs[2] = '{2'd2, 8'hFF, 2'd3, 8'hFF, 2'd2, 8'hFF};
        vecs[3] = '{2'd2, 8'h00, 2'd3, 8'hA5, 2'd3, 8'hA5};
        vecs[4] = '{2'd2, 8'h77, 2'd2, 8'h66, 2'd2, 8'h00};  // shadow only
        vecs[5] = '{2'd1, 8'h08, 2'd1, 8'h08, 2'd1, 8'h46};
        vecs[6] = '{2'd1, 8'h10, 2'd1, 8'h10, 2'd1, 8'h86};
        vecs[7] = '{2'd1, 8'h18, 2'd1, 8'h18, 2'd1, 8'hC6};
        vecs[8] = '{2'd1, 8'h00, 2'd1, 8'h00, 2'd1, 8'h06};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_rda",       {15'd0, rda},       16'd0);
        chk("rst_tbr",       {15'd0, tbr},       16'd1);
        chk("rst_tx_valid",  {15'd0, tx_valid},  16'd0);
        chk("rst_baud_load", {15'd0, baud_load}, 16'd0);
        chk("rst_irq",       {15'd0, irq},       16'd0);
        chk("rst_baud_div",  baud_div,           16'h0145);
        read_chk("rst_status", 2'b01, 8'h06);
        read_chk("rst_div_hi", 2'b11, 8'h01);

        // Register table
        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].a0, vecs[i].d0);
            bus_write(vecs[i].a1, vecs[i].d1);
            read_chk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
        end

        // Two bytes through TX with the serializer always ready
        tx_ready = 1'b1;
        bus_write(2'b00, 8'h41);
        bus_write(2'b00, 8'h42);
        drain_tx("tx_two");
        read_chk("tx_two_status", 2'b01, 8'h06);

        // TX overflow: 17 writes, 16 kept
        for (int i = 0; i < 17; i++) bus_write(2'b00, 8'(8'h10 + i));
        chk("tx_full_tbr", {15'd0, tbr}, 16'd0);
        read_chk("tx_ovf_status", 2'b01, 8'h20);
        bus_write(2'b01, 8'h01);
        read_chk("tx_ovf_clr", 2'b01, 8'h00);
        drain_tx("tx_full");

        // RX overrun: 17 pulses, 16 kept
        for (int i = 0; i < 17; i++) rx_pulse(8'(8'h80 + i));
        read_chk("rx_ovr_status", 2'b01, 8'h1F);
        bus_write(2'b01, 8'h01);
        read_chk("rx_ovr_clr", 2'b01, 8'h0F);

        // Full RX: read and rx_valid in one cycle both succeed
        begin
            logic [DATA_W-1:0] exp;
            exp = rx_q.pop_front();
            rx_q.push_back(8'hC0);
            iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; rx_valid = 1'b1; rx_data = 8'hC0;
            @(negedge clk);
            chk("rx_full_rdwr", {8'h00, databus}, {8'h00, exp});
            tick();
            iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
        end
        read_chk("rx_full_rdwr_status", 2'b01, 8'h0F);
        for (int i = 0; i < 16; i++) read_data($sformatf("rx_rd%0d", i));
        read_data("rx_rd_empty");
        read_chk("rx_empty_status", 2'b01, 8'h06);

        // Divisor commit and load pulse
        bus_write(2'b10, 8'h45);
        chk("baud_load_lo", {15'd0, baud_load}, 16'd0);
        bus_write(2'b11, 8'h01);
        chk("baud_div_commit", baud_div, 16'h0145);
        chk("baud_load_hi", {15'd0, baud_load}, 16'd1);
        tick();
        chk("baud_load_one", {15'd0, baud_load}, 16'd0);

        // RX interrupt rise and fall
        bus_write(2'b01, 8'h08);
        tick();
        chk("irq_idle", {15'd0, irq}, 16'd0);
        rx_pulse(8'h5A);
        chk("irq_rda_up", {15'd0, rda}, 16'd1);
        chk("irq_lag", {15'd0, irq}, 16'd0);
        tick();
        chk("irq_set", {15'd0, irq}, 16'd1);
        read_data("irq_read");
        chk("irq_rda_down", {15'd0, rda}, 16'd0);
        chk("irq_hold", {15'd0, irq}, 16'd1);
        tick();
        chk("irq_clear", {15'd0, irq}, 16'd0);
        bus_write(2'b01, 8'h00);

        // RX flush beats a same-cycle push
        for (int i = 0; i < 3; i++) rx_pulse(8'(8'h30 + i));
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b01; r_drv = 8'h02; r_oe = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        iocs = 1'b0; r_oe = 1'b0; rx_valid = 1'b0;
        rx_q.delete();
        chk("rx_flush_rda", {15'd0, rda}, 16'd0);

        // Reset with entries queued in both FIFOs
        bus_write(2'b10, 8'h34);
        bus_write(2'b11, 8'h12);
        chk("pre_rst_div", baud_div, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            rx_pulse(8'(8'hA0 + i));
            bus_write(2'b00, 8'(8'hB0 + i));
        end
        chk("pre_rst_tx_valid", {15'd0, tx_valid}, 16'd1);
        rst = 1'b1;
        tx_ready = 1'b1;
        #1;
        chk("rst_no_tx_pop", {15'd0, tx_valid}, 16'd0);
        tick();
        rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        chk("mid_rst_rda",      {15'd0, rda},      16'd0);
        chk("mid_rst_tbr",      {15'd0, tbr},      16'd1);
        chk("mid_rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        chk("mid_rst_baud_div", baud_div,          16'h0145);
        tick();
        chk("mid_rst_irq", {15'd0, irq}, 16'd0);
        tx_ready = 1'b0;
        read_chk("mid_rst_status", 2'b01, 8'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spart_buffered_core
`default_nettype wire
